// File: rtl/mon_link_pkg.sv
// Shared definitions for the monitor link: transmitter state type, frame
// lengths and the opcode field position used by the receiver and decoder.
package mon_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_GAP
    } mon_tx_state_e;

    localparam int unsigned MON_LONG_BITS  = 40;
    localparam int unsigned MON_SHORT_BITS = 24;

    // Opcode occupies the top byte of every frame, long or short.
    localparam int unsigned MON_OPC_MSB = 39;
    localparam int unsigned MON_OPC_LSB = 32;

    function automatic logic [5:0] mon_frame_bits(input logic is_long);
        return is_long ? 6'(MON_LONG_BITS) : 6'(MON_SHORT_BITS);
    endfunction

endpackage

// File: rtl/mon_bit_timer.sv
// Bit-period timer: counts 0..BIT_CYCLES-1 and wraps, with synchronous clear.
// tick_o is high for the single cycle in which the count is BIT_CYCLES-1.
module mon_bit_timer #(
    parameter int unsigned BIT_CYCLES = 4,
    localparam int unsigned W = $clog2(BIT_CYCLES)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;

    assign tick_o = (cnt_q == W'(BIT_CYCLES - 1));
    assign cnt_o  = cnt_q;

    // Free-running period counter, reloaded on clear or at end of period.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/mon_host_tx.sv
// Host-side serial transmitter for the monitor link (to_mon line).
// Optional build macro: MON_TX_PARITY_EN adds an even-parity bit after DATA.
module mon_host_tx
    import mon_link_pkg::*;
#(
    parameter int unsigned BIT_CYCLES = 4,
    parameter int unsigned GAP_BITS   = 2
) (
    input  logic        mon_clk,
    input  logic        reset,
    input  logic [39:0] tx_data,
    input  logic        tx_long,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic        to_mon,
    output logic        busy,
    output logic [15:0] frames_sent
);

    localparam int unsigned TW = $clog2(BIT_CYCLES);

    mon_tx_state_e state_q;
    logic [39:0]   sh_q;
    logic [5:0]    bit_cnt_q;
    logic [3:0]    gap_cnt_q;
    logic [15:0]   frames_q;
    logic          to_mon_q;
    logic          ready_q;
    logic          busy_q;
`ifdef MON_TX_PARITY_EN
    logic          par_q;
`endif

    logic          accept;
    logic          leave;
    logic          tick;
    logic          early;
    logic [TW-1:0] tmr_cnt;

    assign accept      = tx_valid && ready_q;
    assign early       = (tmr_cnt == TW'(BIT_CYCLES - 2));
    assign tx_ready    = ready_q;
    assign busy        = busy_q;
    assign to_mon      = to_mon_q;
    assign frames_sent = frames_q;

    mon_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk_i  (mon_clk),
        .rst_i  (reset),
        .clr_i  (leave),
        .cnt_o  (tmr_cnt),
        .tick_o (tick)
    );

    // Decide whether the current state ends on this edge.
    // The final post-stop period ends one cycle early: the line is registered
    // one cycle behind the state, so the IDLE cycle supplies the last idle-high
    // cycle and held-valid frames repeat with exactly the configured gap.
    always_comb begin
        leave = 1'b0;
        unique case (state_q)
            ST_IDLE:  leave = accept;
            ST_START: leave = tick;
            ST_DATA:  leave = tick && (bit_cnt_q == 6'd1);
            ST_PAR:   leave = tick;
            ST_STOP:  leave = (GAP_BITS > 0) ? tick : early;
            ST_GAP:   leave = early && (gap_cnt_q == 4'(GAP_BITS - 1));
            default:  leave = 1'b0;
        endcase
    end

    // Transmit FSM with registered line, handshake and frame counter.
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            frames_q  <= '0;
            to_mon_q  <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
`ifdef MON_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_START: to_mon_q <= 1'b0;
                ST_DATA:  to_mon_q <= sh_q[39];
`ifdef MON_TX_PARITY_EN
                ST_PAR:   to_mon_q <= par_q;
`endif
                default:  to_mon_q <= 1'b1;
            endcase

            unique case (state_q)
                ST_IDLE: begin
                    if (leave) begin
                        sh_q      <= tx_data;
                        bit_cnt_q <= mon_frame_bits(tx_long);
                        state_q   <= ST_START;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
`ifdef MON_TX_PARITY_EN
                        par_q     <= tx_long ? ^tx_data : ^tx_data[39:16];
`endif
                    end
                end
                ST_START: begin
                    if (leave) state_q <= ST_DATA;
                end
                ST_DATA: begin
                    if (tick) begin
                        sh_q      <= {sh_q[38:0], 1'b0};
                        bit_cnt_q <= bit_cnt_q - 6'd1;
                    end
`ifdef MON_TX_PARITY_EN
                    if (leave) state_q <= ST_PAR;
`else
                    if (leave) state_q <= ST_STOP;
`endif
                end
                ST_PAR: begin
                    if (leave) state_q <= ST_STOP;
                end
                ST_STOP: begin
                    if (leave) begin
                        frames_q  <= frames_q + 16'd1;
                        gap_cnt_q <= '0;
                        if (GAP_BITS > 0) begin
                            state_q <= ST_GAP;
                        end else begin
                            state_q <= ST_IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) gap_cnt_q <= gap_cnt_q + 4'd1;
                    if (leave) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mon_host_tx.sv
// Directed bench for mon_host_tx: expected line levels are queued per cycle
// when a frame is offered and compared against to_mon as it is produced.
module tb_mon_host_tx;

    localparam int unsigned BC = 4;
    localparam int unsigned G  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [39:0] tx_data;
    logic        tx_long;
    logic        tx_valid;
    logic        tx_ready;
    logic        to_mon;
    logic        busy;
    logic [15:0] frames_sent;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        exp_q[$];

    always #5 clk = ~clk;

    mon_host_tx #(.BIT_CYCLES(BC), .GAP_BITS(G)) dut (
        .mon_clk     (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_long     (tx_long),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .to_mon      (to_mon),
        .busy        (busy),
        .frames_sent (frames_sent)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned frame_len(input logic lng);
        int unsigned n;
        n = lng ? 40 : 24;
`ifdef MON_TX_PARITY_EN
        n = n + 1;
`endif
        return (2 + n + G) * BC;
    endfunction

    task automatic push_frame(input logic [39:0] d, input logic lng);
        int unsigned n;
        logic        par;
        n   = lng ? 40 : 24;
        par = 1'b0;
        for (int unsigned c = 0; c < BC; c++) exp_q.push_back(1'b0);
        for (int unsigned i = 0; i < n; i++) begin
            par = par ^ d[39-i];
            for (int unsigned c = 0; c < BC; c++) exp_q.push_back(d[39-i]);
        end
`ifdef MON_TX_PARITY_EN
        for (int unsigned c = 0; c < BC; c++) exp_q.push_back(par);
`endif
        for (int unsigned c = 0; c < BC * (1 + G); c++) exp_q.push_back(1'b1);
    endtask

    // Offer a packet and return at the edge on which it is accepted.
    task automatic offer(input logic [39:0] d, input logic lng);
        bit done;
        done = 1'b0;
        @(negedge clk);
        tx_data  = d;
        tx_long  = lng;
        tx_valid = 1'b1;
        for (int i = 0; i < 1000 && !done; i++) begin
            if (tx_ready === 1'b1) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic line_step(input string tag);
        logic e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_underflow"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(to_mon), 32'(e));
        end
    endtask

    task automatic run_frame(input string tag, input logic [39:0] d, input logic lng,
                             input logic [15:0] exp_frames);
        int unsigned len;
        len = frame_len(lng);
        offer(d, lng);
        #1;
        tx_valid = 1'b0;
        tx_data  = ~d;
        tx_long  = ~lng;
        push_frame(d, lng);
        for (int unsigned k = 1; k <= len; k++) begin
            line_step({tag, "_line"});
            if (k == 1) chk({tag, "_busy_start"}, 32'(busy), 32'd1);
            if (k == len - 2) chk({tag, "_ready_late"}, 32'(tx_ready), 32'd0);
            if (k == len - 1) begin
                chk({tag, "_ready_back"}, 32'(tx_ready), 32'd1);
                chk({tag, "_busy_end"}, 32'(busy), 32'd0);
            end
            if (k == len) chk({tag, "_frames"}, 32'(frames_sent), 32'(exp_frames));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned len;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_long  = 1'b0;
        tx_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_to_mon", 32'(to_mon), 32'd1);
            chk("idle_ready", 32'(tx_ready), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_frames", 32'(frames_sent), 32'd0);
        end

        run_frame("long", 40'hA5_0F00_FF01, 1'b1, 16'd1);
        run_frame("short", {24'hC70200, 16'hBEEF}, 1'b0, 16'd2);

        // Back-to-back with valid held high: second frame follows with only the gap.
        len = frame_len(1'b1);
        offer(40'h3C_5A5A_0001, 1'b1);
        #1;
        tx_data = 40'h81_0000_7E00;
        tx_long = 1'b1;
        push_frame(40'h3C_5A5A_0001, 1'b1);
        push_frame(40'h81_0000_7E00, 1'b1);
        for (int unsigned k = 1; k <= len; k++) line_step("b2b_first");
        tx_valid = 1'b0;
        chk("b2b_busy_second", 32'(busy), 32'd1);
        for (int unsigned k = 1; k <= len; k++) line_step("b2b_second");
        chk("b2b_frames", 32'(frames_sent), 32'd4);

        // Reset in the middle of a long frame abandons it.
        offer(40'hFF_FFFF_FFFE, 1'b1);
        #1;
        tx_valid = 1'b0;
        push_frame(40'hFF_FFFF_FFFE, 1'b1);
        for (int unsigned k = 1; k <= 60; k++) line_step("abort_line");
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_to_mon", 32'(to_mon), 32'd1);
        chk("abort_ready", 32'(tx_ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_frames", 32'(frames_sent), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        run_frame("post_abort", {24'h12_3456, 16'h0000}, 1'b0, 16'd1);

        // Single set bit in the LSB position (parity bit is 1 when enabled).
        run_frame("lsb", 40'h00_0000_0001, 1'b1, 16'd2);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
